uart_rx_buf: RTL and testbench

UART_RX_BUF -- requirements
Module: uart_rx_buf

---
 rtl/uart_rx_pkg.sv | 29 ++
 rtl/uart_rx_fifo.sv | 57 +++++
 rtl/uart_rx_buf.sv | 202 ++++++++++++++++++++
 tb/tb_uart_rx_buf.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive buffer.
// States, data-bit encodings and the divider floor.
package uart_rx_pkg;

  localparam int MIN_DIV = 4;

  localparam logic [1:0] BITS_5 = 2'd0;
  localparam logic [1:0] BITS_6 = 2'd1;
  localparam logic [1:0] BITS_7 = 2'd2;
  localparam logic [1:0] BITS_8 = 2'd3;

  localparam logic [7:0] LF_CHAR = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  // index of the last data bit for a bits encoding
  function automatic logic [2:0] last_idx(
    input logic [1:0] bits
  );
    return {1'b0, bits} + 3'd4;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO with wrap-bit pointers.
// ovw_i rewrites the newest entry without moving pointers.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic                     ovw_i,
  input  logic                     pop_i,
  input  logic [7:0]               data_i,
  output logic [7:0]               data_o,
  output logic [$clog2(DEPTH):0]   fill_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW-1:0] newest;

  assign newest  = wr_ptr[AW-1:0] - 1'b1;
  assign fill_o  = wr_ptr - rd_ptr;
  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign data_o  = empty_o ? 8'h00 : mem[rd_ptr[AW-1:0]];

  // pointer update, flush wins over push/pop
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + 1'b1;
      if (pop_i)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // storage write, either a new slot or the newest one
  always_ff @(posedge clk_i) begin
    if (!clr_i) begin
      if (push_i)     mem[wr_ptr[AW-1:0]] <= data_i;
      else if (ovw_i) mem[newest]         <= data_i;
    end
  end

endmodule

// File: rtl/uart_rx_buf.sv
// UART receiver with synchronizer, frame FSM and RX FIFO.
// UART_RX_LINE_DETECT_EN adds eol_o and line-feed overwrite.
module uart_rx_buf
  import uart_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          rx_i,
  input  logic                          cfg_en_i,
  input  logic [DIV_W-1:0]              cfg_div_i,
  input  logic [1:0]                    cfg_bits_i,
  input  logic                          cfg_parity_en_i,
  input  logic                          cfg_parity_odd_i,
  input  logic                          cfg_stop2_i,
  input  logic                          clr_i,
  output logic [7:0]                    rx_data_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic                          parity_err_o,
  output logic                          frame_err_o,
  output logic                          overflow_o,
`ifdef UART_RX_LINE_DETECT_EN
  output logic                          eol_o,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fill_o
);

  rx_state_e        state;
  logic             rx_s1, rx_s2, rx_s3;
  logic [1:0]       age;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_eff;
  logic [DIV_W-1:0] div_m1;
  logic [DIV_W-1:0] half_m1;
  logic [2:0]       idx;
  logic [7:0]       sh;
  logic [1:0]       bits_l;
  logic             par_en_l, odd_l, stop2_l;
  logic             tick, fall;
  logic             par_set, frm_set, ovf_set;
  logic             push_req, wr, ovw, pop;
  logic             full, empty;

  assign div_eff = (cfg_div_i < DIV_W'(MIN_DIV))
                 ? DIV_W'(MIN_DIV) : cfg_div_i;
  assign div_m1  = div_eff - 1'b1;
  assign half_m1 = (div_eff >> 1) - 1'b1;

  assign tick = (state == ST_START) ? (cnt == half_m1)
                                    : (cnt == div_m1);

  // age gates edges until the chain holds real line samples
  assign fall = (age == 2'd3) & rx_s3 & ~rx_s2;

  assign par_set  = cfg_en_i & tick & (state == ST_PARITY) &
                    (rx_s2 != ((^sh) ^ odd_l));
  assign frm_set  = cfg_en_i & tick & (state == ST_STOP) & ~rx_s2;
  assign push_req = cfg_en_i & tick & (state == ST_STOP) & rx_s2 &
                    (~stop2_l | idx[0]);

  assign pop = rx_valid_o & rx_ready_i;
  assign wr  = push_req & (~full | pop);

`ifdef UART_RX_LINE_DETECT_EN
  logic is_lf;
  assign is_lf   = push_req & (sh == LF_CHAR);
  assign ovw     = is_lf & full & ~pop;
  assign eol_o   = is_lf & (wr | ovw) & ~clr_i;
`else
  assign ovw     = 1'b0;
`endif

  assign ovf_set    = push_req & full & ~pop & ~ovw;
  assign rx_valid_o = ~empty;

  // two-flop synchronizer plus edge-detect history
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
      age   <= 2'd0;
    end else begin
      rx_s1 <= rx_i;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
      if (age != 2'd3) age <= age + 2'd1;
    end
  end

  // frame FSM with bit timer and shift register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      idx      <= '0;
      sh       <= '0;
      bits_l   <= BITS_8;
      par_en_l <= 1'b0;
      odd_l    <= 1'b0;
      stop2_l  <= 1'b0;
    end else if (!cfg_en_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (fall) begin
            state    <= ST_START;
            cnt      <= '0;
            idx      <= '0;
            sh       <= '0;
            bits_l   <= cfg_bits_i;
            par_en_l <= cfg_parity_en_i;
            odd_l    <= cfg_parity_odd_i;
            stop2_l  <= cfg_stop2_i;
          end
        end
        ST_START: begin
          if (tick) begin
            cnt   <= '0;
            state <= rx_s2 ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (tick) begin
            cnt     <= '0;
            sh[idx] <= rx_s2;
            if (idx == last_idx(bits_l)) begin
              idx   <= '0;
              state <= par_en_l ? ST_PARITY : ST_STOP;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (tick) begin
            cnt   <= '0;
            state <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (tick) begin
            cnt <= '0;
            if (!rx_s2 || !stop2_l || idx[0])
              state <= ST_IDLE;
            else
              idx <= 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // sticky error flags, flush takes priority
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overflow_o   <= 1'b0;
    end else if (clr_i) begin
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      if (par_set) parity_err_o <= 1'b1;
      if (frm_set) frame_err_o  <= 1'b1;
      if (ovf_set) overflow_o   <= 1'b1;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .clr_i   (clr_i),
    .push_i  (wr),
    .ovw_i   (ovw),
    .pop_i   (pop),
    .data_i  (sh),
    .data_o  (rx_data_o),
    .fill_o  (fill_o),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule

// File: tb/tb_uart_rx_buf.sv
// Randomized bench for uart_rx_buf against a frame-level model.
// Model tracks the byte queue and sticky flags per frame.
`timescale 1ns/1ps
module tb_uart_rx_buf;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rx;
  logic        en;
  logic [15:0] div;
  logic [1:0]  bits;
  logic        pe, odd, stop2, clr, ready;
  logic [7:0]  data;
  logic        valid, perr, ferr, ovf;
  logic [3:0]  fill;
`ifdef UART_RX_LINE_DETECT_EN
  logic        eol;
  int          eol_cnt;
`endif

  always #5 clk = ~clk;

  uart_rx_buf #(
    .FIFO_DEPTH (DEPTH),
    .DIV_W      (16)
  ) dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .rx_i             (rx),
    .cfg_en_i         (en),
    .cfg_div_i        (div),
    .cfg_bits_i       (bits),
    .cfg_parity_en_i  (pe),
    .cfg_parity_odd_i (odd),
    .cfg_stop2_i      (stop2),
    .clr_i            (clr),
    .rx_data_o        (data),
    .rx_valid_o       (valid),
    .rx_ready_i       (ready),
    .parity_err_o     (perr),
    .frame_err_o      (ferr),
    .overflow_o       (ovf),
`ifdef UART_RX_LINE_DETECT_EN
    .eol_o            (eol),
`endif
    .fill_o           (fill)
  );

`ifdef UART_RX_LINE_DETECT_EN
  always @(posedge clk) if (eol === 1'b1) eol_cnt++;
`endif

  int         n_run;
  int         n_fail;
  logic [7:0] q[$];
  bit         m_perr, m_ferr, m_ovf;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [7:0] head;
    head = (q.size() != 0) ? q[0] : 8'h00;
    chk({tag, ".fill"}, 32'(fill), q.size());
    chk({tag, ".valid"}, 32'(valid), 32'(q.size() != 0));
    chk({tag, ".data"}, 32'(data), 32'(head));
    chk({tag, ".perr"}, 32'(perr), 32'(m_perr));
    chk({tag, ".ferr"}, 32'(ferr), 32'(m_ferr));
    chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
  endtask

  task automatic model_push(input logic [7:0] b);
    if (q.size() < DEPTH) q.push_back(b);
`ifdef UART_RX_LINE_DETECT_EN
    else if (b == 8'h0A) q[q.size()-1] = b;
`endif
    else m_ovf = 1'b1;
  endtask

  task automatic wait_bit();
    repeat (int'(div)) @(negedge clk);
  endtask

  // bad_stop: 0 none, 1 first stop low, 2 second stop low
  // drop_bit: data bit during which the enable falls, -1 none
  task automatic send(input logic [7:0] b, input int nb,
                      input bit bad_par, input int bad_stop,
                      input int drop_bit);
    int         n;
    logic [7:0] m;
    logic       pbit;
    n = nb + 5;
    m = b & (8'hFF >> (8 - n));
    pbit = (^m) ^ odd;
    if (bad_par) pbit = ~pbit;
    rx = 1'b0;
    wait_bit();
    for (int i = 0; i < n; i++) begin
      rx = m[i];
      if (i == drop_bit) begin
        repeat (int'(div) / 2) @(negedge clk);
        en = 1'b0;
        repeat (int'(div) - int'(div) / 2) @(negedge clk);
      end else begin
        wait_bit();
      end
    end
    if (pe) begin
      rx = pbit;
      wait_bit();
    end
    rx = (bad_stop == 1) ? 1'b0 : 1'b1;
    wait_bit();
    if (stop2) begin
      rx = (bad_stop == 2) ? 1'b0 : 1'b1;
      wait_bit();
    end
    rx = 1'b1;
    wait_bit();
    en = 1'b1;
    repeat (2) @(negedge clk);
    if (drop_bit < 0) begin
      if (pe && bad_par) m_perr = 1'b1;
      if (bad_stop != 0) m_ferr = 1'b1;
      else model_push(m);
    end
  endtask

  task automatic pop_chk();
    logic [7:0] tmp;
    if (q.size() != 0) begin
      chk("pop.data", 32'(data), 32'(q[0]));
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      tmp = q.pop_front();
    end
  endtask

  task automatic clear_all();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    q.delete();
    m_perr = 1'b0;
    m_ferr = 1'b0;
    m_ovf  = 1'b0;
  endtask

  initial begin
    int bs;
    bit bp;
    int np;
    n_run  = 0;
    n_fail = 0;
    m_perr = 1'b0;
    m_ferr = 1'b0;
    m_ovf  = 1'b0;
    rstn   = 1'b0;
    rx     = 1'b1;
    en     = 1'b1;
    div    = 16'd16;
    bits   = 2'd3;
    pe     = 1'b0;
    odd    = 1'b0;
    stop2  = 1'b0;
    clr    = 1'b0;
    ready  = 1'b0;
`ifdef UART_RX_LINE_DETECT_EN
    eol_cnt = 0;
`endif
    repeat (3) @(negedge clk);
    check_state("reset");
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    send(8'h55, 3, 1'b0, 0, -1);
    check_state("8n1");
    clear_all();
    check_state("clr0");

    bits = 2'd2;
    pe   = 1'b1;
    send(8'h41, 2, 1'b1, 0, -1);
    check_state("7e1");
    clear_all();
    check_state("clr1");

    bits  = 2'd3;
    pe    = 1'b0;
    stop2 = 1'b1;
    send(8'hA5, 3, 1'b0, 2, -1);
    check_state("8n2");
    clear_all();

    stop2 = 1'b0;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check_state("glitch");

    send(8'h3C, 3, 1'b0, 0, 3);
    check_state("en_drop");
    send(8'h81, 3, 1'b0, 0, -1);
    check_state("recover");
    clear_all();

    for (int i = 0; i < 9; i++) send(8'(i), 3, 1'b0, 0, -1);
    check_state("ovf");
    for (int i = 0; i < 8; i++) pop_chk();
    check_state("drained");
    clear_all();

`ifdef UART_RX_LINE_DETECT_EN
    eol_cnt = 0;
    send(8'h0A, 3, 1'b0, 0, -1);
    chk("eol.count", 32'(eol_cnt), 32'd1);
    check_state("eol");
    clear_all();
`endif

    for (int k = 0; k < 40; k++) begin
      div   = 16'($urandom_range(8, 24));
      bits  = 2'($urandom_range(0, 3));
      pe    = 1'($urandom_range(0, 1));
      odd   = 1'($urandom_range(0, 1));
      stop2 = 1'($urandom_range(0, 1));
      bp    = ($urandom_range(0, 7) == 0);
      bs    = 0;
      if ($urandom_range(0, 9) == 0)
        bs = stop2 ? int'($urandom_range(1, 2)) : 1;
      send(8'($urandom_range(0, 255)), int'(bits),
           bp, bs, -1);
      check_state("rnd");
      np = int'($urandom_range(0, 2));
      for (int j = 0; j < np; j++) pop_chk();
      if ($urandom_range(0, 9) == 0) begin
        clear_all();
        check_state("rnd_clr");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
